// File: rtl/clock_alarm_pkg.sv
// clock_alarm_pkg: shared alarm state encodings and default timing parameters
package clock_alarm_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} alarm_state_t;
   localparam int DEF_RING_SECS   = 60;
   localparam int DEF_SNOOZE_SECS = 300;
   localparam int DEF_MAX_SNOOZE  = 3;
endpackage

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: alarm ring/snooze sequencer with 1 s on/off beep cadence
module alarm_ring_ctrl
   import clock_alarm_pkg::*;
#(
   parameter int RING_SECS   = DEF_RING_SECS,
   parameter int SNOOZE_SECS = DEF_SNOOZE_SECS,
   parameter int MAX_SNOOZE  = DEF_MAX_SNOOZE
)(
   input  logic       CLK,
   input  logic       RST,
   input  logic       tick_1hz,
   input  logic       EN_work,
   input  logic       judge,
   input  logic       key_stop,
   input  logic       key_snooze,
   output logic       buzzer,
   output logic       ringing,
   output logic       snoozing,
   output logic [1:0] snooze_cnt
);
   localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
   localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
   localparam logic [1:0] SNZ_MAX     = 2'(MAX_SNOOZE);
   alarm_state_t state, state_n;
   logic [8:0] sec_cnt, sec_n;
   logic [1:0] snz_n;
   logic phase, phase_n, judge_q, armed, rise;
   // armed blocks a judge level that was already high across reset until it drops
   assign rise = judge & ~judge_q & armed;
   always_comb begin
      state_n = state;
      sec_n   = sec_cnt;
      phase_n = phase;
      snz_n   = snooze_cnt;
      if (EN_work) begin
         state_n = IDLE;
         sec_n   = '0;
         snz_n   = '0;
      end else if (state == IDLE) begin
         if (rise) begin
            state_n = RING;
            sec_n   = '0;
            snz_n   = '0;
            phase_n = 1'b1;
         end
      end else if (state == RING) begin
         if (key_stop) begin
            state_n = IDLE;
            snz_n   = '0;
         end else if (key_snooze && snooze_cnt < SNZ_MAX) begin
            state_n = SNOOZE;
            snz_n   = snooze_cnt + 2'd1;
            sec_n   = '0;
         end else if (tick_1hz) begin
            phase_n = ~phase;
            state_n = (sec_cnt == RING_LAST) ? IDLE : RING;
            sec_n   = (sec_cnt == RING_LAST) ? sec_cnt : sec_cnt + 9'd1;
         end
      end else if (state == SNOOZE) begin
         if (key_stop) begin
            state_n = IDLE;
            snz_n   = '0;
         end else if (tick_1hz) begin
            state_n = (sec_cnt == SNOOZE_LAST) ? RING : SNOOZE;
            sec_n   = (sec_cnt == SNOOZE_LAST) ? 9'd0 : sec_cnt + 9'd1;
            phase_n = (sec_cnt == SNOOZE_LAST) ? 1'b1 : phase;
         end
      end else begin
         state_n = IDLE;
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         sec_cnt    <= '0;
         phase      <= 1'b0;
         snooze_cnt <= '0;
         judge_q    <= 1'b0;
         armed      <= ~judge;
         buzzer     <= 1'b0;
         ringing    <= 1'b0;
         snoozing   <= 1'b0;
      end else begin
         state      <= state_n;
         sec_cnt    <= sec_n;
         phase      <= phase_n;
         snooze_cnt <= snz_n;
         judge_q    <= judge;
         armed      <= armed | ~judge;
         buzzer     <= (state_n == RING) & phase_n;
         ringing    <= state_n == RING;
         snoozing   <= state_n == SNOOZE;
      end
   end
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: directed checks of ring, snooze, stop, EN_work and reset behaviour
module tb_alarm_ring_ctrl;
   logic CLK = 1'b0, RST = 1'b1, tick_1hz = 1'b0, EN_work = 1'b0, judge = 1'b0;
   logic key_stop = 1'b0, key_snooze = 1'b0;
   logic buzzer, ringing, snoozing;
   logic [1:0] snooze_cnt;
   int n_tests = 0, n_fail = 0;

   alarm_ring_ctrl #(.RING_SECS(5), .SNOOZE_SECS(3), .MAX_SNOOZE(2)) dut (
      .CLK(CLK), .RST(RST), .tick_1hz(tick_1hz), .EN_work(EN_work), .judge(judge),
      .key_stop(key_stop), .key_snooze(key_snooze), .buzzer(buzzer), .ringing(ringing),
      .snoozing(snoozing), .snooze_cnt(snooze_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic do_tick();
      repeat (9) cyc();
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
   endtask

   // expected is {buzzer, ringing, snoozing, snooze_cnt[1:0]}
   task automatic chk(input string tag, input logic [4:0] exp);
      logic [4:0] got;
      got = {buzzer, ringing, snoozing, snooze_cnt};
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   initial begin
      cyc();
      cyc();
      chk("reset", 5'b00000);
      RST = 1'b0;
      cyc();
      chk("idle_after_reset", 5'b00000);
      // basic ring with auto-stop
      judge = 1'b1;
      cyc();
      chk("ring_start", 5'b11000);
      for (int i = 1; i <= 4; i++) begin
         do_tick();
         chk($sformatf("beep_tick%0d", i), (i % 2) ? 5'b01000 : 5'b11000);
      end
      do_tick();
      chk("auto_stop", 5'b00000);
      repeat (30) cyc();
      chk("judge_held_no_rering", 5'b00000);
      judge = 1'b0;
      cyc();
      // snooze path and snooze limit
      judge = 1'b1;
      cyc();
      chk("ring2_start", 5'b11000);
      key_snooze = 1'b1;
      cyc();
      key_snooze = 1'b0;
      chk("snooze1", 5'b00101);
      do_tick();
      do_tick();
      chk("snooze1_mid", 5'b00101);
      do_tick();
      chk("rering1", 5'b11001);
      key_snooze = 1'b1;
      cyc();
      key_snooze = 1'b0;
      chk("snooze2", 5'b00110);
      repeat (3) do_tick();
      chk("rering2", 5'b11010);
      key_snooze = 1'b1;
      cyc();
      key_snooze = 1'b0;
      chk("snooze3_ignored", 5'b11010);
      key_stop = 1'b1;
      cyc();
      key_stop = 1'b0;
      chk("stop_clears", 5'b00000);
      judge = 1'b0;
      cyc();
      // stop beats snooze
      judge = 1'b1;
      cyc();
      chk("ring3_start", 5'b11000);
      key_stop = 1'b1;
      key_snooze = 1'b1;
      cyc();
      key_stop = 1'b0;
      key_snooze = 1'b0;
      chk("stop_over_snooze", 5'b00000);
      judge = 1'b0;
      cyc();
      // EN_work during snooze
      judge = 1'b1;
      cyc();
      key_snooze = 1'b1;
      cyc();
      key_snooze = 1'b0;
      chk("snooze_before_en", 5'b00101);
      EN_work = 1'b1;
      cyc();
      EN_work = 1'b0;
      chk("en_work_idle", 5'b00000);
      repeat (3) do_tick();
      chk("en_work_no_rering", 5'b00000);
      judge = 1'b0;
      cyc();
      // reset mid-ring with judge held high
      judge = 1'b1;
      cyc();
      chk("ring4_start", 5'b11000);
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      chk("reset_mid_ring", 5'b00000);
      do_tick();
      repeat (5) cyc();
      chk("judge_high_after_reset", 5'b00000);
      judge = 1'b0;
      cyc();
      judge = 1'b1;
      cyc();
      chk("rise_after_reset", 5'b11000);
      key_stop = 1'b1;
      cyc();
      key_stop = 1'b0;
      judge = 1'b0;
      cyc();
      // stop coincident with final ring tick
      judge = 1'b1;
      cyc();
      key_snooze = 1'b1;
      cyc();
      key_snooze = 1'b0;
      repeat (3) do_tick();
      chk("ring5_rering", 5'b11001);
      repeat (4) do_tick();
      chk("ring5_tick4", 5'b11001);
      repeat (9) cyc();
      tick_1hz = 1'b1;
      key_stop = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      key_stop = 1'b0;
      chk("stop_on_final_tick", 5'b00000);
      judge = 1'b0;
      cyc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
